demux_1x4_seq: RTL and testbench
================================

DEMUX_1X4_SEQ -- requirements
Module: demux_1x4_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, the data width of the input and of each output channel.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 The module SHALL have port in_data, input, WIDTH, the data beat to be routed.
REQ-005 The module SHALL have port in_valid, input, 1, indicating in_data is offered.
REQ-006 The module SHALL have port in_ready, output, 1, indicating the currently selected channel can take a beat.
REQ-007 The module SHALL have ports s1 (LSB) and s2 (MSB), each input, 1, the manual channel select {s2,s1}.
REQ-008 The module SHALL have port auto_mode, input, 1: 1 = round-robin select, 0 = manual select.
REQ-009 The module SHALL have port out, output, 4*WIDTH, the channel k holding register at out[k*WIDTH +: WIDTH].
REQ-010 The module SHALL have port out_valid, output, 4, bit k meaning channel k holds an undrained beat.
REQ-011 The module SHALL have port out_ready, input, 4, bit k meaning the channel k consumer takes the beat.
REQ-012 The module SHALL have port rr_ptr, output, 2, the current round-robin pointer.

Function
REQ-013 The effective select sel SHALL be rr_ptr when auto_mode=1, else {s2,s1}; it is sampled combinationally in the cycle of acceptance.
REQ-014 in_ready SHALL be combinational: 0 while rst=1; otherwise ~out_valid[sel] | out_ready[sel].
REQ-015 A beat SHALL be accepted when in_valid=1 and in_ready=1 at a rising clk edge.
REQ-016 On acceptance, out[sel] SHALL load in_data and out_valid[sel] SHALL be 1 after that edge (1-cycle latency); other channels are unaffected.
REQ-017 Channel k SHALL drain when out_valid[k]=1 and out_ready[k]=1; out_valid[k] clears after that edge unless the same edge accepts a new beat into k.
REQ-018 When a drain and an accept hit the same channel on one edge, out[k] SHALL take the new data and out_valid[k] SHALL stay 1 (no bubble).
REQ-019 out[k] SHALL hold its value while out_valid[k]=1 and out_ready[k]=0; it retains stale data after a drain.
REQ-020 Drains on different channels in the same cycle SHALL all complete independently.
REQ-021 rr_ptr SHALL advance by 1 only on an accepted beat while auto_mode=1, wrapping 3 -> 0.
REQ-022 rr_ptr SHALL hold its value while auto_mode=0; switching modes does not reset it.
REQ-023 in_valid=1 with in_ready=0 SHALL leave all state unchanged (stall), and rr_ptr SHALL NOT advance.
REQ-024 A change of s1, s2 or auto_mode during a stall SHALL retarget the pending beat to the new sel with no state change.

Reset
REQ-025 While rst=1, out SHALL be 0, out_valid SHALL be 4'b0000, rr_ptr SHALL be 2'b00 and in_ready SHALL be 0, asynchronously and independent of clk.
REQ-026 Reset asserted mid-operation SHALL discard all held beats with no drain indication.
REQ-027 After rst deasserts, in_ready SHALL be 1 and the block accepts a beat on the first clk edge.

Verification
REQ-028 Manual routing: auto_mode=0, out_ready=4'b1111, send 8'h01, 8'h02, 8'h04, 8'h08 with {s2,s1}=00, 01, 10, 11 -> each appears on out channel 0, 1, 2, 3 one cycle later, with out_valid one-hot 0001, 0010, 0100, 1000.
REQ-029 Backpressure: out_ready=0, {s2,s1}=10, send 8'hA5 then 8'h5A -> out_valid=4'b0100 and in_ready=0 on the second beat; raise out_ready[2] -> 8'h5A is accepted on the same edge, out[2]=8'h5A, out_valid[2] stays 1.
REQ-030 Round-robin: auto_mode=1, out_ready=4'b1111, five back-to-back beats 8'h10..8'h14 -> channels 0, 1, 2, 3, 0 receive them, and rr_ptr reads 1 at the end.
REQ-031 Stall freeze: auto_mode=1, channel 1 full with out_ready[1]=0, rr_ptr=1, in_valid=1 for 3 cycles -> rr_ptr stays 1 and no channel changes.
REQ-032 Async reset: with out_valid=4'b1011, assert rst mid-cycle -> out=0, out_valid=0, rr_ptr=0 and in_ready=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/demux_1x4_seq.sv
// 1-to-4 streaming demultiplexer with a holding register per channel.
// The channel is picked manually via {s2,s1} or by a round-robin pointer that steps on each accepted beat.
module demux_1x4_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               s1,
    input  logic               s2,
    input  logic               auto_mode,
    output logic [4*WIDTH-1:0] out,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [1:0]         rr_ptr
);

    logic [4*WIDTH-1:0] out_q, out_d;
    logic [3:0]         out_valid_q, out_valid_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [1:0]         sel;
    logic               accept;

    assign sel      = auto_mode ? rr_ptr_q : {s2, s1};
    // A full channel still takes a beat when its consumer drains on the same edge.
    assign in_ready = ~rst & (~out_valid_q[sel] | out_ready[sel]);
    assign accept   = in_valid & in_ready;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q & ~out_ready;
        rr_ptr_d    = rr_ptr_q;
        for (int k = 0; k < 4; k++) begin
            if (accept && (sel == 2'(k))) begin
                out_d[k*WIDTH +: WIDTH] = in_data;
                out_valid_d[k]          = 1'b1;
            end
        end
        if (accept && auto_mode) begin
            rr_ptr_d = rr_ptr_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 4'b0000;
            rr_ptr_q    <= 2'b00;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_demux_1x4_seq.sv
// Testbench for demux_1x4_seq: directed scenarios pinned with literal values,
// then randomized traffic compared every cycle against a behavioural channel model.
module tb_demux_1x4_seq;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic           s1, s2, auto_mode;
    logic [4*W-1:0] out;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready;
    logic [1:0]     rr_ptr;

    int checks = 0;
    int errors = 0;

    // Behavioural model: four holding slots, their occupancy, and the pointer
    logic [W-1:0] mdl_data [4];
    bit           mdl_valid[4];
    int           mdl_ptr;

    demux_1x4_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .s1(s1), .s2(s2), .auto_mode(auto_mode),
        .out(out), .out_valid(out_valid), .out_ready(out_ready), .rr_ptr(rr_ptr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mdl_sel();
        return auto_mode ? mdl_ptr : int'({s2, s1});
    endfunction

    function automatic bit mdl_ready();
        if (rst) return 1'b0;
        return !mdl_valid[mdl_sel()] || out_ready[mdl_sel()];
    endfunction

    task automatic mdl_reset();
        for (int k = 0; k < 4; k++) begin
            mdl_data[k]  = '0;
            mdl_valid[k] = 1'b0;
        end
        mdl_ptr = 0;
    endtask

    task automatic checkOutput();
        logic [4*W-1:0] exp_out;
        logic [3:0]     exp_valid;
        for (int k = 0; k < 4; k++) begin
            exp_out[k*W +: W] = mdl_data[k];
            exp_valid[k]      = mdl_valid[k];
        end
        check("in_ready",  64'(in_ready),  64'(mdl_ready()));
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        check("out",       64'(out),       64'(exp_out));
        check("rr_ptr",    64'(rr_ptr),    64'(mdl_ptr));
    endtask

    // Called at a falling edge; returns at the next falling edge with the model advanced
    task automatic applyStimulus(input logic [W-1:0] d, input logic v, input logic a,
                                 input logic ss1, input logic ss2, input logic [3:0] ordy);
        bit acc;
        int sel;
        in_data   = d;
        in_valid  = v;
        auto_mode = a;
        s1        = ss1;
        s2        = ss2;
        out_ready = ordy;
        #1;
        checkOutput();
        acc = v && mdl_ready();
        sel = mdl_sel();
        @(posedge clk);
        for (int k = 0; k < 4; k++)
            if (mdl_valid[k] && ordy[k]) mdl_valid[k] = 1'b0;
        if (acc) begin
            mdl_data[sel]  = d;
            mdl_valid[sel] = 1'b1;
            if (a) mdl_ptr = (mdl_ptr + 1) % 4;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] k2;
        logic       cur_auto;
        rst = 1'b1;
        in_data = '0; in_valid = 1'b0; auto_mode = 1'b0; s1 = 1'b0; s2 = 1'b0; out_ready = 4'b0000;
        mdl_reset();
        repeat (2) @(negedge clk);
        checkOutput();
        check("reset_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", 64'(in_ready), 64'd1);

        // Manual routing: each beat lands on its selected channel one cycle later
        for (int k = 0; k < 4; k++) begin
            k2 = 2'(k);
            applyStimulus(8'(8'h01 << k), 1'b1, 1'b0, k2[0], k2[1], 4'b1111);
            check("manual_data",  64'(out[k*W +: W]), 64'(8'h01 << k));
            check("manual_valid", 64'(out_valid),     64'(4'b0001 << k));
        end
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);
        check("manual_drained", 64'(out_valid), 64'd0);

        // Backpressure on channel 2, then same-edge drain and refill
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
        check("bp_first_valid", 64'(out_valid), 64'h4);
        applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
        check("bp_stall_ready", 64'(in_ready), 64'd0);
        check("bp_stall_hold",  64'(out[2*W +: W]), 64'hA5);
        applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100);
        check("bp_refill_data",  64'(out[2*W +: W]), 64'h5A);
        check("bp_refill_valid", 64'(out_valid), 64'h4);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);

        // Round-robin: five beats wrap around to channel 0
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'(8'h10 + i), 1'b1, 1'b1, 1'b0, 1'b0, 4'b1111);
            check("rr_data", 64'(out[(i % 4)*W +: W]), 64'(8'h10 + i));
        end
        check("rr_ptr_end", 64'(rr_ptr), 64'd1);
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1111);

        // Stall freeze: channel 1 full and blocked with the pointer on it
        applyStimulus(8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'(8'hC0 + i), 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
            check("freeze_ptr",   64'(rr_ptr), 64'd1);
            check("freeze_valid", 64'(out_valid), 64'h2);
            check("freeze_data",  64'(out[1*W +: W]), 64'h77);
        end

        // Async reset in the middle of a cycle with three channels loaded
        applyStimulus(8'h30, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        applyStimulus(8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000);
        check("pre_reset_valid", 64'(out_valid), 64'hB);
        #2;
        rst = 1'b1;
        #1;
        check("async_out",       64'(out), 64'd0);
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_rr_ptr",    64'(rr_ptr), 64'd0);
        check("async_in_ready",  64'(in_ready), 64'd0);
        mdl_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("release_in_ready", 64'(in_ready), 64'd1);

        // Randomized traffic, mode flipped occasionally to exercise retargeting
        cur_auto = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) cur_auto = ~cur_auto;
            applyStimulus(8'($urandom), ($urandom_range(0, 9) < 7), cur_auto,
                          1'($urandom), 1'($urandom), 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
